// File: rtl/multicycle_control.sv
// Multicycle main control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives ALU control, PC/IR/register/memory strobes, and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16,
  parameter int OPC_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic [1:0]       alu_op_o,
  output logic             alu_src_b_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             wb_sel_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             trap_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(8);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [1:0]         alu_op_s, pc_src_s;
  logic               alu_src_b_s, pc_write_s, ir_write_s, reg_write_s;
  logic               wb_sel_s, mem_read_s, mem_write_s, retire_s;

  // State register and retired-instruction counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    alu_op_s    = ALU_ADD;
    alu_src_b_s = 1'b0;
    pc_write_s  = 1'b0;
    pc_src_s    = 2'b00;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    wb_sel_s    = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    retire_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready_i) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode_i > OP_J) begin
          state_d = S_TRAP;
        end else if (opcode_i == OP_J) begin
          pc_write_s = 1'b1;
          pc_src_s   = 2'b10;
          retire_s   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (opcode_i)
          OP_ADD:  alu_op_s = ALU_ADD;
          OP_SUB:  alu_op_s = ALU_SUB;
          OP_AND:  alu_op_s = ALU_AND;
          OP_ADDI: alu_src_b_s = 1'b1;
          OP_ANDI: begin
            alu_op_s    = ALU_AND;
            alu_src_b_s = 1'b1;
          end
          OP_LW, OP_SW: begin
            alu_src_b_s = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            alu_op_s = ALU_SUB;
            if (zero_i) begin
              pc_write_s = 1'b1;
              pc_src_s   = 2'b01;
            end else begin
              pc_write_s = 1'b0;
            end
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        alu_src_b_s = 1'b1;
        if (opcode_i == OP_SW) begin
          mem_write_s = 1'b1;
        end else begin
          mem_read_s  = 1'b1;
        end
        if (!mem_ready_i) begin
          state_d = S_MEM;
        end else if (opcode_i == OP_SW) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        wb_sel_s    = (opcode_i == OP_LW);
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    retired_d = retire_s ? retired_q + CNT_W'(1) : retired_q;
  end

  // Strobes are forced low while reset is held, even though FETCH would request memory.
  assign pc_write_o  = pc_write_s  & ~reset_i;
  assign ir_write_o  = ir_write_s  & ~reset_i;
  assign reg_write_o = reg_write_s & ~reset_i;
  assign mem_read_o  = mem_read_s  & ~reset_i;
  assign mem_write_o = mem_write_s & ~reset_i;
  assign alu_op_o    = alu_op_s;
  assign alu_src_b_o = alu_src_b_s;
  assign pc_src_o    = pc_src_s;
  assign wb_sel_o    = wb_sel_s;
  assign trap_o      = (state_q == S_TRAP);
  assign state_o     = state_q;
  assign retired_o   = retired_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control sequencer for the simple RISC core; sits directly upstream of the ALU.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU's AluOp and operand-B select, plus PC, IR, register-file and data-memory strobes.
- Consumes the ALU zero flag and a memory ready handshake; counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- OPC_W, 6, width of opcode field.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPC_W  instruction[31:26] from the IR; stable from DECODE onward.
- zero  input  1  ALU Output == 0, combinational from the ALU.
- mem_ready  input  1  memory completes the current access this cycle.
- alu_op  output  2  to ALU AluOp; uses the ALU_Add/ALU_Sub/ALU_And encodings from constants.v.
- alu_src_b  output  1  0 = register operand, 1 = sign-extended immediate.
- pc_write  output  1  PC load strobe.
- pc_src  output  2  00 = PC+4, 01 = branch target, 10 = jump target.
- ir_write  output  1  IR load strobe.
- reg_write  output  1  register-file write strobe.
- wb_sel  output  1  0 = ALU result, 1 = memory data.
- mem_read  output  1  memory read request (instruction or data).
- mem_write  output  1  data-memory write request.
- trap  output  1  sticky illegal-opcode flag.
- state  output  3  current state, for debug.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, ADDI=3, ANDI=4, LW=5, SW=6, BEQ=7, J=8. Values 9–63 are illegal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (async, any state, mid-access included):
  - state = FETCH, retired = 0, trap = 0.
  - All strobes (pc_write, ir_write, reg_write, mem_read, mem_write) = 0 while reset is high.
  - alu_op = ALU_Add, alu_src_b = 0, pc_src = 00, wb_sel = 0.
- Outputs are combinational from state, opcode, zero and mem_ready. Any strobe not listed for a state is 0.
- FETCH:
  - mem_read = 1.
  - If mem_ready: ir_write = 1, pc_write = 1, pc_src = 00; next state DECODE.
  - Otherwise hold in FETCH with no other strobes.
- DECODE:
  - Illegal opcode → TRAP.
  - J: pc_write = 1, pc_src = 10; → FETCH, retired++.
  - All other opcodes → EXEC.
- EXEC:
  - ADD/SUB/AND: alu_src_b = 0, alu_op = Add/Sub/And respectively; → WB.
  - ADDI/ANDI: alu_src_b = 1, alu_op = Add/And; → WB.
  - LW/SW: alu_src_b = 1, alu_op = ALU_Add; → MEM.
  - BEQ: alu_src_b = 0, alu_op = ALU_Sub. If zero: pc_write = 1, pc_src = 01. → FETCH, retired++ (taken or not).
- MEM:
  - LW: mem_read = 1. SW: mem_write = 1. alu_op/alu_src_b held at EXEC values (Add, 1).
  - Without mem_ready: hold in MEM, request kept asserted.
  - With mem_ready: LW → WB; SW → FETCH, retired++.
- WB:
  - reg_write = 1; wb_sel = 1 for LW, else 0.
  - → FETCH, retired++.
- TRAP:
  - trap = 1, all strobes 0, remains until reset.
  - retired is not incremented for the illegal instruction.
- retired:
  - Increments exactly once per instruction, on the clock edge leaving its final state.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
- mem_read and mem_write are never asserted in the same cycle.
- Latency with mem_ready tied to 1:
  - R/I-type ALU ops and LW: 4 and 5 cycles respectively.
  - SW: 4 cycles; BEQ: 3 cycles; J: 2 cycles.

Test Plan:
- Reset held 3 cycles, then released, mem_ready = 1, opcode = 0 (ADD) → states 0,1,2,4,0; reg_write = 1 only in WB; alu_op = ALU_Add, alu_src_b = 0 in EXEC; retired = 1.
- opcode = 5 (LW), mem_ready low for 2 cycles in MEM → MEM held 3 cycles with mem_read = 1; WB has wb_sel = 1, reg_write = 1; 7 cycles total from FETCH entry.
- opcode = 7 (BEQ), zero = 1 in EXEC → pc_write = 1, pc_src = 01 there. Repeat with zero = 0 → pc_write = 0 in EXEC. Both take 3 cycles; retired += 2.
- opcode = 6 (SW) then 8 (J) → SW asserts mem_write in MEM with no reg_write, 4 cycles; J asserts pc_write with pc_src = 10 in DECODE, 2 cycles.
- opcode = 12 → TRAP entered after DECODE; trap = 1, all strobes 0 for 20 cycles, retired unchanged. Async reset mid-cycle clears trap and returns to FETCH immediately.
- Preload via 65535 retired ADDs (CNT_W = 16), then one more → retired wraps to 0. Async reset asserted during MEM with mem_write = 1 → mem_write drops immediately.
